// File: rtl/lsu_mem_ctrl.sv
// Load/store controller between the memory pipeline stage and a 64-bit data RAM.
// Handles B/H/W/D loads with extension, read-modify-write sub-word stores, and misalignment faults.
module lsu_mem_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_unsigned_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              resp_valid_o,
  output logic [DATA_W-1:0] resp_rdata_o,
  output logic              resp_misalign_o,
  output logic [ADDR_W-1:0] mem_rd_addr_o,
  output logic              mem_rd_en_o,
  input  logic [DATA_W-1:0] mem_rd_data_i,
  output logic [ADDR_W-1:0] mem_wr_addr_o,
  output logic              mem_wr_en_o,
  output logic [DATA_W-1:0] mem_wr_data_o
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_e;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        size_q, size_d;
  logic              we_q, we_d;
  logic              uns_q, uns_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] merged_q, merged_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              misalign_q, misalign_d;

  logic              accept;
  logic              req_misaligned;
  logic [5:0]        shamt;
  logic [ADDR_W-1:0] aligned_addr;
  logic [DATA_W-1:0] rd_shifted;
  logic [DATA_W-1:0] field_mask;
  logic [DATA_W-1:0] lane_mask;
  logic [DATA_W-1:0] merged_w;
  logic [DATA_W-1:0] load_fmt;
  logic              sign_bit;

  // Ready drops with rst_n so nothing is accepted while reset is held.
  assign req_ready_o  = rst_n && (state_q == IDLE);
  assign accept       = req_valid_i && req_ready_o;
  assign resp_valid_o = (state_q == RESP);
  assign resp_rdata_o    = rdata_q;
  assign resp_misalign_o = misalign_q;

  assign shamt        = {addr_q[2:0], 3'b000};
  assign aligned_addr = {addr_q[ADDR_W-1:3], 3'b000};
  assign rd_shifted   = mem_rd_data_i >> shamt;
  assign lane_mask    = field_mask << shamt;
  assign merged_w     = (mem_rd_data_i & ~lane_mask) | ((wdata_q << shamt) & lane_mask);

  always_comb begin
    // NOTE: every variable written here gets a default first, so no latch is inferred.
    req_misaligned = 1'b0;
    unique case (req_size_i)
      SZ_H:    req_misaligned = req_addr_i[0];
      SZ_W:    req_misaligned = |req_addr_i[1:0];
      SZ_D:    req_misaligned = |req_addr_i[2:0];
      default: req_misaligned = 1'b0;
    endcase
  end

  always_comb begin
    field_mask = '1;
    sign_bit   = 1'b0;
    load_fmt   = rd_shifted;
    unique case (size_q)
      SZ_B: begin
        field_mask = DATA_W'(8'hFF);
        sign_bit   = rd_shifted[7] & ~uns_q;
        load_fmt   = {{(DATA_W-8){sign_bit}}, rd_shifted[7:0]};
      end
      SZ_H: begin
        field_mask = DATA_W'(16'hFFFF);
        sign_bit   = rd_shifted[15] & ~uns_q;
        load_fmt   = {{(DATA_W-16){sign_bit}}, rd_shifted[15:0]};
      end
      SZ_W: begin
        field_mask = DATA_W'(32'hFFFF_FFFF);
        sign_bit   = rd_shifted[31] & ~uns_q;
        load_fmt   = {{(DATA_W-32){sign_bit}}, rd_shifted[31:0]};
      end
      default: begin
        field_mask = '1;
        load_fmt   = mem_rd_data_i;
      end
    endcase
  end

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    size_d        = size_q;
    we_d          = we_q;
    uns_d         = uns_q;
    wdata_d       = wdata_q;
    merged_d      = merged_q;
    rdata_d       = rdata_q;
    misalign_d    = misalign_q;
    mem_rd_en_o   = 1'b0;
    mem_rd_addr_o = '0;
    mem_wr_en_o   = 1'b0;
    mem_wr_addr_o = '0;
    mem_wr_data_o = '0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d  = req_addr_i;
          size_d  = req_size_i;
          we_d    = req_we_i;
          uns_d   = req_unsigned_i;
          wdata_d = req_wdata_i;
          if (req_misaligned) begin
            rdata_d    = '0;
            misalign_d = 1'b1;
            state_d    = RESP;
          end else if (req_we_i && req_size_i == SZ_D) begin
            state_d = WR;
          end else begin
            state_d = RD;
          end
        end
      end
      RD: begin
        mem_rd_en_o   = 1'b1;
        mem_rd_addr_o = aligned_addr;
        if (we_q) begin
          merged_d = merged_w;
          state_d  = WR;
        end else begin
          rdata_d    = load_fmt;
          misalign_d = 1'b0;
          state_d    = RESP;
        end
      end
      WR: begin
        mem_wr_en_o   = 1'b1;
        mem_wr_addr_o = aligned_addr;
        mem_wr_data_o = (size_q == SZ_D) ? wdata_q : merged_q;
        rdata_d       = '0;
        misalign_d    = 1'b0;
        state_d       = RESP;
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      size_q     <= '0;
      we_q       <= 1'b0;
      uns_q      <= 1'b0;
      wdata_q    <= '0;
      merged_q   <= '0;
      rdata_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state_q    <= state_d;
      addr_q     <= addr_d;
      size_q     <= size_d;
      we_q       <= we_d;
      uns_q      <= uns_d;
      wdata_q    <= wdata_d;
      merged_q   <= merged_d;
      rdata_q    <= rdata_d;
      misalign_q <= misalign_d;
    end
  end

endmodule
